router_port_sink: RTL and testbench

- Consumes one router output port: drains the port FIFO through `vld_out`/`read_enb`.
- Parses header `{len[5:0], addr[1:0]}`, streams payload bytes downstream over a valid/ready interface and checks the trailing parity byte.
- One instance per output port (0, 1, 2), directly downstream of the router top.
- Always reads promptly when it has buffer space, so the router's port is not left unread.

---
 rtl/router_port_sink.sv | 200 ++++++++++++++++++++
 tb/tb_router_port_sink.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_sink.sv
// Drains one router output port, parses the {len,addr} header, streams the payload through a skid FIFO and checks the parity byte.
// Latency: the header read edge is followed by one header cycle, and each payload byte is pushed one edge after its read.
// Backpressure: reads stop when the buffered bytes plus the read in flight reach DEPTH; the parity read needs no buffer space.
//
// Ports: clock/resetn (async active-low); vld_out_i/data_out_i/read_enb_o = router port read side;
//        m_data/m_valid/m_ready/m_last = payload stream; pkt_done/pkt_len/pkt_addr/parity_err/trunc_err =
//        per-packet status strobe; busy_o = packet in progress.
// Optional feature: define SINK_TIMEOUT_EN to abort a packet whose port stays empty for STALL_MAX cycles mid-packet.
module router_port_sink #(
  parameter int DEPTH     = 4,
  parameter int STALL_MAX = 32
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vld_out_i,
  input  logic [7:0] data_out_i,
  output logic       read_enb_o,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_last,
  output logic       pkt_done,
  output logic [5:0] pkt_len,
  output logic [1:0] pkt_addr,
  output logic       parity_err,
  output logic       trunc_err,
  output logic       busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_len;
  logic [1:0]  r_addr;
  logic [6:0]  r_to_issue;   // reads still to issue: payload plus parity
  logic [5:0]  r_rcvd;       // bytes captured so far in BODY
  logic        r_inflight;   // a BODY read was accepted last edge; its data is on the bus now
  logic [7:0]  r_xor;        // running XOR of header and captured payload
  logic        r_pkt_done;
  logic [5:0]  r_pkt_len;
  logic [1:0]  r_pkt_addr;
  logic        r_parity_err;
  logic        r_trunc_err;
  logic        r_busy;

  logic [8:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_rd_en;
  logic w_capture;
  logic w_push;
  logic w_is_parity;
  logic w_pop;
  logic w_last;
  logic w_stall_hit;

  // The credit counts the read in flight so a push can never land on a full FIFO.
  always_comb begin
    w_rd_en = 1'b0;
    case (r_state)
      S_IDLE:  w_rd_en = vld_out_i;
      S_BODY:  w_rd_en = vld_out_i && (r_to_issue != 7'd0) &&
                         ((r_to_issue == 7'd1) || (int'(r_count) + int'(r_inflight) < DEPTH));
      default: w_rd_en = 1'b0;
    endcase
  end

  assign w_capture   = (r_state == S_BODY) && r_inflight;
  assign w_push      = w_capture && (r_rcvd < r_len);
  assign w_is_parity = w_capture && (r_rcvd == r_len);
  assign w_last      = (r_rcvd == r_len - 6'd1);
  assign w_pop       = (r_count != '0) && m_ready;

`ifdef SINK_TIMEOUT_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  logic [SW-1:0] r_stall;
  logic          w_stall_cond;

  assign w_stall_cond = (r_state == S_BODY) && (r_to_issue != 7'd0) && !vld_out_i;
  assign w_stall_hit  = w_stall_cond && (int'(r_stall) + 1 >= STALL_MAX);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_stall <= '0;
    end else if (w_stall_cond && !w_stall_hit) begin
      r_stall <= r_stall + 1'b1;
    end else begin
      r_stall <= '0;
    end
  end
`else
  assign w_stall_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_addr       <= '0;
      r_to_issue   <= '0;
      r_rcvd       <= '0;
      r_inflight   <= 1'b0;
      r_xor        <= '0;
      r_pkt_done   <= 1'b0;
      r_pkt_len    <= '0;
      r_pkt_addr   <= '0;
      r_parity_err <= 1'b0;
      r_trunc_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pkt_done <= 1'b0;
      r_inflight <= (r_state == S_BODY) && w_rd_en;
      case (r_state)
        S_IDLE: begin
          if (w_rd_en) begin
            r_state <= S_HDR;
            r_busy  <= 1'b1;
          end
        end
        S_HDR: begin
          r_len      <= data_out_i[7:2];
          r_addr     <= data_out_i[1:0];
          r_to_issue <= {1'b0, data_out_i[7:2]} + 7'd1;
          r_rcvd     <= '0;
          r_xor      <= data_out_i;
          r_state    <= S_BODY;
        end
        S_BODY: begin
          if (w_rd_en) begin
            r_to_issue <= r_to_issue - 7'd1;
          end
          if (w_capture) begin
            r_rcvd <= r_rcvd + 6'd1;
            r_xor  <= r_xor ^ data_out_i;
          end
          if (w_is_parity) begin
            r_pkt_done   <= 1'b1;
            r_pkt_len    <= r_len;
            r_pkt_addr   <= r_addr;
            r_parity_err <= ((r_xor ^ data_out_i) != 8'd0);
            r_trunc_err  <= 1'b0;
            r_state      <= S_DONE;
          end else if (w_stall_hit) begin
            r_pkt_done   <= 1'b1;
            r_pkt_len    <= r_len;
            r_pkt_addr   <= r_addr;
            r_parity_err <= 1'b0;
            r_trunc_err  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Skid FIFO; storage is cleared on reset so the head reads 0 out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_last, data_out_i};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign read_enb_o = w_rd_en;
  assign m_valid    = (r_count != '0);
  assign m_data     = r_mem[r_rd_ptr][7:0];
  assign m_last     = r_mem[r_rd_ptr][8];
  assign pkt_done   = r_pkt_done;
  assign pkt_len    = r_pkt_len;
  assign pkt_addr   = r_pkt_addr;
  assign parity_err = r_parity_err;
  assign trunc_err  = r_trunc_err;
  assign busy_o     = r_busy;

endmodule

// File: tb/tb_router_port_sink.sv
// Bench for router_port_sink: a router-port model with one-cycle read latency feeds packets,
// a payload scoreboard and a status scoreboard are filled at stimulus time and drained by monitors.
// Build with SINK_TIMEOUT_EN defined to exercise the stall timeout as well.
module tb_router_port_sink;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
    logic       perr;
    logic       terr;
  } stat_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       vld_out_i;
  logic [7:0] data_out_i = 8'd0;
  logic       read_enb_o;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       pkt_done;
  logic [5:0] pkt_len;
  logic [1:0] pkt_addr;
  logic       parity_err;
  logic       trunc_err;
  logic       busy_o;

  logic port_vld = 1'b0;
  logic fire     = 1'b0;
  logic fix_rdy  = 1'b1;
  logic rand_rdy = 1'b0;
  logic rnd_rdy  = 1'b0;
  logic saw_valid = 1'b0;

  logic [7:0] port_q [$];
  logic [8:0] exp_q  [$];
  stat_t      stat_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int n_bytes  = 0;
  int done_cnt = 0;

  assign vld_out_i = port_vld && resetn;
  assign m_ready   = rand_rdy ? rnd_rdy : fix_rdy;

  router_port_sink #(.DEPTH(4), .STALL_MAX(32)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .vld_out_i  (vld_out_i),
    .data_out_i (data_out_i),
    .read_enb_o (read_enb_o),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .pkt_done   (pkt_done),
    .pkt_len    (pkt_len),
    .pkt_addr   (pkt_addr),
    .parity_err (parity_err),
    .trunc_err  (trunc_err),
    .busy_o     (busy_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Router port model: a read seen at an edge presents the next byte shortly after that edge.
  always @(posedge clock) begin
    #1;
    if (fire && port_q.size() > 0) data_out_i = port_q.pop_front();
    port_vld = (port_q.size() != 0);
    rnd_rdy  = 1'($urandom_range(0, 1));
  end

  // Monitors sample on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    fire = read_enb_o && vld_out_i;
    if (fire) n_reads++;
    if (m_valid) saw_valid = 1'b1;
    if (resetn && m_valid && m_ready) begin
      n_bytes++;
      if (exp_q.size() == 0) check("extra_byte", {23'd0, m_last, m_data}, 32'h1ff);
      else check("payload", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
    end
    if (resetn && pkt_done) begin
      done_cnt++;
      if (stat_q.size() == 0) begin
        check("extra_done", 32'd1, 32'd0);
      end else begin
        stat_t s;
        s = stat_q.pop_front();
        check("pkt_len", {26'd0, pkt_len}, {26'd0, s.len});
        check("pkt_addr", {30'd0, pkt_addr}, {30'd0, s.addr});
        check("parity_err", {31'd0, parity_err}, {31'd0, s.perr});
        check("trunc_err", {31'd0, trunc_err}, {31'd0, s.terr});
      end
    end
  end

  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input logic bad);
    logic [7:0] hdr;
    logic [7:0] b;
    logic [7:0] x;
    stat_t s;
    hdr = {len, addr};
    x = hdr;
    port_q.push_back(hdr);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom_range(0, 255));
      x = x ^ b;
      port_q.push_back(b);
      exp_q.push_back({1'(i == int'(len) - 1), b});
    end
    port_q.push_back(x ^ {7'd0, bad});
    s.len = len; s.addr = addr; s.perr = bad; s.terr = 1'b0;
    stat_q.push_back(s);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(posedge clock);
      k++;
    end
    check("done_wait", {31'd0, 1'(done_cnt >= target)}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < 300) begin
      @(posedge clock);
      k++;
    end
    repeat (2) @(posedge clock);
    check(tag, exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] out_vec();
    return {9'd0, read_enb_o, m_valid, m_last, m_data, pkt_done, pkt_len, pkt_addr,
            parity_err, trunc_err, busy_o};
  endfunction

  initial begin
    int r0;
    int b0;
    int k;
    int d;

    // Reset state
    #1 resetn = 1'b0;
    #2;
    check("reset_outputs", out_vec(), 32'd0);
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;
    repeat (2) @(posedge clock);
    check("idle_busy", {31'd0, busy_o}, 32'd0);

    // Nominal packet, header 0x39
    r0 = n_reads;
    send_pkt(6'd14, 2'd1, 1'b0);
    wait_done(1, 400);
    drain("nominal_left");
    check("nominal_reads", n_reads - r0, 32'd16);
    check("nominal_busy", {31'd0, busy_o}, 32'd0);

    // Bad parity, payload still delivered
    send_pkt(6'd14, 2'd1, 1'b1);
    wait_done(2, 400);
    drain("badpar_left");

    // Backpressure: reads stop once the buffer credit is used up
    fix_rdy = 1'b0;
    r0 = n_reads;
    send_pkt(6'd14, 2'd1, 1'b0);
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("bp_reads", n_reads - r0, 32'd5);
    check("bp_read_enb", {31'd0, read_enb_o}, 32'd0);
    check("bp_busy", {31'd0, busy_o}, 32'd1);
    fix_rdy = 1'b1;
    wait_done(3, 400);
    drain("bp_left");
    check("bp_total_reads", n_reads - r0, 32'd16);

    // Zero-length packet: header 0x02, parity 0x02
    saw_valid = 1'b0;
    send_pkt(6'd0, 2'd2, 1'b0);
    wait_done(4, 100);
    repeat (3) @(posedge clock);
    check("zero_len_valid", {31'd0, saw_valid}, 32'd0);

    // Back-to-back packets with random downstream readiness
    rand_rdy = 1'b1;
    send_pkt(6'd1, 2'd0, 1'b0);
    send_pkt(6'd7, 2'd3, 1'b0);
    send_pkt(6'd0, 2'd1, 1'b1);
    send_pkt(6'd20, 2'd2, 1'b0);
    wait_done(8, 1000);
    drain("b2b_left");
    rand_rdy = 1'b0;
    check("b2b_port_empty", port_q.size(), 32'd0);

    // Reset in the middle of a packet
    b0 = n_bytes;
    send_pkt(6'd10, 2'd1, 1'b0);
    k = 0;
    while (n_bytes - b0 < 5 && k < 200) begin
      @(posedge clock);
      k++;
    end
    check("mid_bytes", {31'd0, 1'(n_bytes - b0 >= 5)}, 32'd1);
    @(posedge clock);
    #3 resetn = 1'b0;
    port_q.delete();
    exp_q.delete();
    stat_q.delete();
    #1;
    check("mid_reset_outputs", out_vec(), 32'd0);
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    d = done_cnt;
    send_pkt(6'd9, 2'd3, 1'b0);
    wait_done(d + 1, 400);
    drain("post_reset_left");

`ifdef SINK_TIMEOUT_EN
    // Port runs dry after 5 payload bytes of a 14-byte packet
    begin
      stat_t s;
      logic [7:0] b;
      port_q.push_back({6'd14, 2'd1});
      for (int i = 0; i < 5; i++) begin
        b = 8'($urandom_range(0, 255));
        port_q.push_back(b);
        exp_q.push_back({1'b0, b});
      end
      s.len = 6'd14; s.addr = 2'd1; s.perr = 1'b0; s.terr = 1'b1;
      stat_q.push_back(s);
      d = done_cnt;
      wait_done(d + 1, 200);
      drain("timeout_left");
      check("timeout_busy", {31'd0, busy_o}, 32'd0);
    end
`endif

    repeat (3) @(posedge clock);
    check("final_stat_left", stat_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
